regbank_write_arbiter: RTL

REGBANK_WRITE_ARBITER -- requirements
Module: regbank_write_arbiter

---
 rtl/regbank_pkg.sv | 26 ++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/regbank_write_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank write arbiter: widths, requester IDs
// and the two-state round-robin encoding.
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NREG     = 16;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  localparam logic [0:0] PRI0 = 1'b0;
  localparam logic [0:0] PRI1 = 1'b1;

  // After a transfer the other requester gets the tie-break; idle cycles hold.
  function automatic logic [0:0] favour_after(input logic [1:0] grant,
                                              input logic [0:0] cur);
    if (grant[REQ_ALU])
      return PRI1;
    else if (grant[REQ_LOAD])
      return PRI0;
    else
      return cur;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant selection; a lone requester always wins, ties go to
// whichever requester the state favours.
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic [1:0] valid,
  input  logic [0:0] state,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01: grant[REQ_ALU]  = 1'b1;
      2'b10: grant[REQ_LOAD] = 1'b1;
      2'b11: begin
        if (state == PRI1)
          grant[REQ_LOAD] = 1'b1;
        else
          grant[REQ_ALU] = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto one register-bank write port and
// tracks per-register pending-write (busy) bits for hazard checks.
module regbank_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [2*ADDR_W-1:0]   req_dest,
  input  logic [2*DATA_W-1:0]   req_data,
  output logic [1:0]            req_ready,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_dest,
  input  logic [ADDR_W-1:0]     chk_addr1,
  input  logic [ADDR_W-1:0]     chk_addr2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_dest,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  grant_id,
  output logic                  err_unres
);

  import regbank_pkg::*;

  localparam int NR = 1 << ADDR_W;

  logic [1:0]        grant;
  logic [0:0]        state_reg;
  logic [NR-1:0]     busy_reg;
  logic [NR-1:0]     busy_next;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_dest_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              grant_id_reg;
  logic              err_unres_reg;

  logic [ADDR_W-1:0] dest_s [2];
  logic [DATA_W-1:0] data_s [2];
  logic              xfer;
  logic              sel;
  logic [ADDR_W-1:0] xfer_dest;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slice
      assign dest_s[gi] = req_dest[gi*ADDR_W +: ADDR_W];
      assign data_s[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter2 u_arb (
    .valid (req_valid),
    .state (state_reg),
    .grant (grant)
  );

  // Nothing may be accepted while reset is held, so ready is gated by rst_n.
  assign req_ready = rst_n ? grant : 2'b00;
  assign xfer      = |req_ready;
  assign sel       = req_ready[REQ_LOAD];
  assign xfer_dest = dest_s[sel];

  // Clear first, then set, so a same-edge reserve of the written register wins.
  always_comb begin
    busy_next = busy_reg;
    if (xfer)
      busy_next[xfer_dest] = 1'b0;
    if (rsv_valid)
      busy_next[rsv_dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PRI0;
      busy_reg      <= '0;
      wr_en_reg     <= 1'b0;
      wr_dest_reg   <= '0;
      wr_data_reg   <= '0;
      grant_id_reg  <= 1'b0;
      err_unres_reg <= 1'b0;
    end else begin
      state_reg     <= favour_after(req_ready, state_reg);
      busy_reg      <= busy_next;
      wr_en_reg     <= xfer;
      err_unres_reg <= xfer & ~busy_reg[xfer_dest];
      if (xfer) begin
        wr_dest_reg  <= xfer_dest;
        wr_data_reg  <= data_s[sel];
        grant_id_reg <= sel;
      end
    end
  end

  assign chk_busy1 = busy_reg[chk_addr1];
  assign chk_busy2 = busy_reg[chk_addr2];
  assign wr_en     = wr_en_reg;
  assign wr_dest   = wr_dest_reg;
  assign wr_data   = wr_data_reg;
  assign grant_id  = grant_id_reg;
  assign err_unres = err_unres_reg;

endmodule
